// File: rtl/branch_sequencer.sv
// branch_sequencer: program counter owner with conditional/relative branches
// and call/return through a small internal return-address stack.
module branch_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter int                  STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int                 CNT_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                increment,
  input  logic                execute,
  input  logic [2:0]          br_op,
  input  logic [1:0]          cond_sel,
  input  logic                cond_inv,
  input  logic [3:0]          flags,
  input  logic                rel,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                taken,
  output logic [CNT_W-1:0]    stack_count,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  localparam int IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STACK_SLOTS = 1 << IDX_W;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_JUMP = 3'b001,
    OP_CJMP = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } br_op_e;

  logic [PC_WIDTH-1:0] stack_mem [0:STACK_SLOTS-1];
  logic                skip;

  logic                cond_bit;
  logic [PC_WIDTH-1:0] dest;
  logic                do_push;
  logic                do_pop;
  logic                redirect;
  logic                err_set;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic [PC_WIDTH-1:0] pc_next;
  logic [CNT_W-1:0]    count_next;

  assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);

  // Decode the branch request and work out next pc, stack movement and faults.
  always_comb begin
    cond_bit   = flags[cond_sel] ^ cond_inv;
    dest       = rel ? (pc + target) : target;
    push_idx   = IDX_W'(stack_count);
    pop_idx    = IDX_W'(stack_count - CNT_W'(1));
    do_push    = 1'b0;
    do_pop     = 1'b0;
    redirect   = 1'b0;
    err_set    = 1'b0;
    pc_next    = pc;
    count_next = stack_count;

    if (execute) begin
      case (br_op)
        OP_JUMP: redirect = 1'b1;
        OP_CJMP: redirect = cond_bit;
        OP_CALL: begin
          if (stack_full) begin
            err_set = 1'b1;
          end else begin
            do_push  = 1'b1;
            redirect = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_set = 1'b1;
          end else begin
            do_pop   = 1'b1;
            redirect = 1'b1;
          end
        end
        default: redirect = 1'b0;
      endcase
    end

    if (redirect) begin
      pc_next = do_pop ? stack_mem[pop_idx] : dest;
    end else if (increment && !skip) begin
      pc_next = pc + PC_WIDTH'(1);
    end

    if (do_push) begin
      count_next = stack_count + CNT_W'(1);
    end else if (do_pop) begin
      count_next = stack_count - CNT_W'(1);
    end
  end

  // Control state: pc, taken pulse, fetch-skip flag, stack depth and sticky fault.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc          <= RESET_VECTOR;
      taken       <= 1'b0;
      skip        <= 1'b0;
      stack_count <= '0;
      stack_err   <= 1'b0;
    end else begin
      pc          <= pc_next;
      taken       <= redirect;
      skip        <= redirect;
      stack_count <= count_next;
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Return-address storage; contents are don't-care after clear so no reset.
  always_ff @(posedge clock) begin
    if (!clear && do_push) begin
      stack_mem[push_idx] <= pc;
    end
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Parametrised successor to the decoder's jump gating logic.
- Owns the program counter, evaluates conditional branches against a selectable flag with optional inversion, and supports absolute/relative targets plus call/return through an internal return-address stack.
- Sits between the decoder (branch strobes) and instruction fetch (pc), consuming ALU flag registers.

Parameters:
- PC_WIDTH, 8, width of pc, target and stack entries (>=4)
- STACK_DEPTH, 4, number of return-stack entries (>=1)
- RESET_VECTOR, 0, pc value loaded on clear

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- clear  in  1  synchronous active-high reset
- increment  in  1  fetch-phase advance request (pc+1)
- execute  in  1  execute-phase strobe; br_op sampled only when high
- br_op  in  3  000 none, 001 jump, 010 cond jump, 011 call, 100 return, others = none
- cond_sel  in  2  flag select: 0 Z, 1 C, 2 N, 3 V
- cond_inv  in  1  invert selected flag (jnz/jnc style)
- flags  in  4  {V,N,C,Z} from flag registers
- rel  in  1  0 absolute target, 1 target is signed offset added to pc
- target  in  PC_WIDTH  jump/call address or offset
- pc  out  PC_WIDTH  current program counter
- taken  out  1  registered one-cycle pulse: branch/call/return redirected pc
- stack_count  out  clog2(STACK_DEPTH+1)  occupied stack entries
- stack_full, stack_empty  out  1  combinational from stack_count
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (clear).
- clear (sampled on edge): pc=RESET_VECTOR, taken=0, stack_count=0, stack_err=0, skip=0; stack contents don't-care. Clear overrides all other inputs same cycle, including mid-branch.
- cond = flags[cond_sel] XOR cond_inv.
- dest = rel ? (pc + target) mod 2^PC_WIDTH : target (target treated as two's complement when rel=1).
- Redirect when execute=1 and: br_op=jump; br_op=cond jump and cond=1; br_op=call and not full; br_op=return and not empty.
- Redirect actions (next edge): jump/cond -> pc=dest; call -> push pc, pc=dest; return -> pc=pop value (target/rel ignored). taken=1 for that one cycle after, else 0.
- Skip register: skip <= redirect each cycle. increment is ignored while skip=1 (the cycle after a redirect), so the target address is fetched unincremented.
- Priority per cycle: clear > redirect > (increment & !skip) -> pc+1 mod 2^PC_WIDTH > hold.
- Execute without redirect (br_op none, cond false, faulted call/return) with increment=1 and skip=0 -> pc+1.
- Call with stack full: no push, no redirect, stack_err=1 (sticky until clear); increment proceeds normally.
- Return with stack empty: no pop, no redirect, stack_err=1.
- Stack is LIFO; push and pop never both occur in one cycle. stack_count changes by exactly +/-1 per successful call/return.
- pc wraps 2^PC_WIDTH-1 -> 0 on increment; relative add wraps modulo 2^PC_WIDTH.
- Zero combinational path from inputs to pc/taken; stack_full/empty derive only from registered count.

Test Plan:
- clear, then 3 cycles increment=1 -> pc 0,1,2,3; taken=0; pc=8'hFF + increment -> 8'h00.
- pc=10, execute, br_op=cond jump, cond_sel=Z, cond_inv=1, flags Z=0, target=8'h40 -> pc=8'h40, taken pulse; increment held high next cycle ignored -> pc stays 8'h40 one cycle then 8'h41. Same with Z=1 -> pc=11, taken=0.
- pc=8'h20, rel=1, target=8'hFC, br_op=jump -> pc=8'h1C; pc=8'hFE, target=8'h05 -> pc=8'h03.
- STACK_DEPTH=4: 4 calls from pc 1,2,3,4 to 8'h80.. -> stack_count=4, full=1; 5th call -> pc unchanged, stack_err=1; 4 returns -> pc 4,3,2,1, empty=1.
- Return on empty stack -> stack_err=1, pc advances by increment only; stays 1 until clear.
- clear asserted same cycle as a taken call with count=2 -> pc=RESET_VECTOR, stack_count=0, taken=0, stack_err=0.
